// File: rtl/axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter
//   Two-master AXI read arbiter. m0 (icache) and m1 (dcache) share one
//   memory-bus read port. A three-state FSM (IDLE/ADDR/DATA) grants one
//   master per burst. The owner is held until its rlast beat, and at least
//   one idle cycle separates bursts. Ties go round-robin (RR=1) or to m0
//   (RR=0).
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   arvalid_m*/ar_m*/arready_m*   per-master read-address channel
//   rvalid_m*/r_m*/rready_m*      per-master read-data channel
//   arvalid1/ar1/arready1         shared bus read-address channel
//   rvalid1/r1/rready1            shared bus read-data channel (r1[0] = rlast)
//   grant                         one-hot bus owner (bit0 = m0), 00 when idle
//   busy                          high in ADDR or DATA
// ---------------------------------------------------------------------------
module axi_rd_arbiter #(
    parameter int RR   = 1,
    parameter int AR_W = 45,
    parameter int R_W  = 67
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            arvalid_m0,
    input  logic            arvalid_m1,
    input  logic [AR_W-1:0] ar_m0,
    input  logic [AR_W-1:0] ar_m1,
    output logic            arready_m0,
    output logic            arready_m1,
    output logic            rvalid_m0,
    output logic            rvalid_m1,
    output logic [R_W-1:0]  r_m0,
    output logic [R_W-1:0]  r_m1,
    input  logic            rready_m0,
    input  logic            rready_m1,
    output logic            arvalid1,
    output logic [AR_W-1:0] ar1,
    input  logic            arready1,
    input  logic            rvalid1,
    input  logic [R_W-1:0]  r1,
    output logic            rready1,
    output logic [1:0]      grant,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t     state, state_nxt;
    logic [1:0] grant_q, grant_nxt;
    logic       m1_next_q, m1_next_nxt;   // round-robin pointer: 1 = m1 wins next tie
    logic [7:0] beat_cnt, beat_cnt_nxt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant_q   <= 2'b00;
            m1_next_q <= 1'b0;
            beat_cnt  <= 8'd0;
        end else begin
            state     <= state_nxt;
            grant_q   <= grant_nxt;
            m1_next_q <= m1_next_nxt;
            beat_cnt  <= beat_cnt_nxt;
        end
    end

    // NOTE: every signal written in a combinational block gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant_q;
        m1_next_nxt  = m1_next_q;
        beat_cnt_nxt = beat_cnt;
        case (state)
            IDLE: begin
                if (arvalid_m0 || arvalid_m1) begin
                    state_nxt = ADDR;
                    if (arvalid_m0 && arvalid_m1)
                        grant_nxt = (RR != 0 && m1_next_q) ? 2'b10 : 2'b01;
                    else
                        grant_nxt = arvalid_m0 ? 2'b01 : 2'b10;
                end
            end
            ADDR: begin
                if (arvalid1 && arready1) begin
                    state_nxt    = DATA;
                    beat_cnt_nxt = 8'd0;
                end
            end
            DATA: begin
                if (rvalid1 && rready1) begin
                    beat_cnt_nxt = beat_cnt + 8'd1;
                    if (r1[0]) begin
                        state_nxt   = IDLE;
                        // m0 just finished, so m1 gets the next tie, and vice versa.
                        m1_next_nxt = grant_q[0];
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Channel muxing is purely combinational from the registered state. An
    // asynchronous reset therefore drops every output without waiting for a
    // clock edge.
    always_comb begin
        arvalid1   = 1'b0;
        ar1        = '0;
        arready_m0 = 1'b0;
        arready_m1 = 1'b0;
        rvalid_m0  = 1'b0;
        rvalid_m1  = 1'b0;
        r_m0       = '0;
        r_m1       = '0;
        rready1    = 1'b0;
        grant      = 2'b00;
        busy       = 1'b0;
        case (state)
            ADDR: begin
                busy  = 1'b1;
                grant = grant_q;
                if (grant_q[0]) begin
                    arvalid1   = arvalid_m0;
                    ar1        = ar_m0;
                    arready_m0 = arready1;
                end else begin
                    arvalid1   = arvalid_m1;
                    ar1        = ar_m1;
                    arready_m1 = arready1;
                end
            end
            DATA: begin
                busy  = 1'b1;
                grant = grant_q;
                if (grant_q[0]) begin
                    rvalid_m0 = rvalid1;
                    r_m0      = r1;
                    rready1   = rready_m0;
                end else begin
                    rvalid_m1 = rvalid1;
                    r_m1      = r1;
                    rready1   = rready_m1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_arbiter
//   Directed bench for axi_rd_arbiter. Two instances share all inputs: one
//   round-robin (RR=1) and one fixed-priority (RR=0). use_fp selects which
//   instance's outputs are checked. A reset pulse resynchronises the two
//   instances after any tie section.
// ---------------------------------------------------------------------------
module tb_axi_rd_arbiter;
    localparam int AR_W = 45;
    localparam int R_W  = 67;

    localparam logic [AR_W-1:0] AR0 = {32'h8000_0040, 2'b01, 8'd8, 3'd3};
    localparam logic [AR_W-1:0] AR1 = {32'h4000_1000, 2'b01, 8'd2, 3'd3};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            arvalid_m0 = 0, arvalid_m1 = 0;
    logic [AR_W-1:0] ar_m0 = AR0, ar_m1 = AR1;
    logic            rready_m0 = 0, rready_m1 = 0;
    logic            arready1 = 0, rvalid1 = 0;
    logic [R_W-1:0]  r1 = '0;

    // round-robin instance outputs
    logic            arready_m0_r, arready_m1_r, rvalid_m0_r, rvalid_m1_r;
    logic [R_W-1:0]  r_m0_r, r_m1_r;
    logic            arvalid1_r, rready1_r, busy_r;
    logic [AR_W-1:0] ar1_r;
    logic [1:0]      grant_r;
    // fixed-priority instance outputs
    logic            arready_m0_f, arready_m1_f, rvalid_m0_f, rvalid_m1_f;
    logic [R_W-1:0]  r_m0_f, r_m1_f;
    logic            arvalid1_f, rready1_f, busy_f;
    logic [AR_W-1:0] ar1_f;
    logic [1:0]      grant_f;

    axi_rd_arbiter #(.RR(1), .AR_W(AR_W), .R_W(R_W)) dut (
        .clk(clk), .rst(rst),
        .arvalid_m0(arvalid_m0), .arvalid_m1(arvalid_m1), .ar_m0(ar_m0), .ar_m1(ar_m1),
        .arready_m0(arready_m0_r), .arready_m1(arready_m1_r),
        .rvalid_m0(rvalid_m0_r), .rvalid_m1(rvalid_m1_r), .r_m0(r_m0_r), .r_m1(r_m1_r),
        .rready_m0(rready_m0), .rready_m1(rready_m1),
        .arvalid1(arvalid1_r), .ar1(ar1_r), .arready1(arready1),
        .rvalid1(rvalid1), .r1(r1), .rready1(rready1_r),
        .grant(grant_r), .busy(busy_r)
    );

    axi_rd_arbiter #(.RR(0), .AR_W(AR_W), .R_W(R_W)) dut_fp (
        .clk(clk), .rst(rst),
        .arvalid_m0(arvalid_m0), .arvalid_m1(arvalid_m1), .ar_m0(ar_m0), .ar_m1(ar_m1),
        .arready_m0(arready_m0_f), .arready_m1(arready_m1_f),
        .rvalid_m0(rvalid_m0_f), .rvalid_m1(rvalid_m1_f), .r_m0(r_m0_f), .r_m1(r_m1_f),
        .rready_m0(rready_m0), .rready_m1(rready_m1),
        .arvalid1(arvalid1_f), .ar1(ar1_f), .arready1(arready1),
        .rvalid1(rvalid1), .r1(r1), .rready1(rready1_f),
        .grant(grant_f), .busy(busy_f)
    );

    bit              use_fp = 1'b0;
    logic            o_arready_m0, o_arready_m1, o_rvalid_m0, o_rvalid_m1;
    logic [R_W-1:0]  o_r_m0, o_r_m1;
    logic            o_arvalid1, o_rready1, o_busy;
    logic [AR_W-1:0] o_ar1;
    logic [1:0]      o_grant;

    always_comb begin
        if (use_fp) begin
            o_arready_m0 = arready_m0_f; o_arready_m1 = arready_m1_f;
            o_rvalid_m0  = rvalid_m0_f;  o_rvalid_m1  = rvalid_m1_f;
            o_r_m0       = r_m0_f;       o_r_m1       = r_m1_f;
            o_arvalid1   = arvalid1_f;   o_rready1    = rready1_f;
            o_busy       = busy_f;       o_ar1        = ar1_f;
            o_grant      = grant_f;
        end else begin
            o_arready_m0 = arready_m0_r; o_arready_m1 = arready_m1_r;
            o_rvalid_m0  = rvalid_m0_r;  o_rvalid_m1  = rvalid_m1_r;
            o_r_m0       = r_m0_r;       o_r_m1       = r_m1_r;
            o_arvalid1   = arvalid1_r;   o_rready1    = rready1_r;
            o_busy       = busy_r;       o_ar1        = ar1_r;
            o_grant      = grant_r;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to 2 ns after the next rising edge; inputs change here, and
    // checks follow a further #1, well clear of both clock edges.
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    function automatic logic [R_W-1:0] beat(input int n, input bit last);
        return {64'hD00D_0000_0000_0000 + 64'(n), 2'b00, last};
    endfunction

    task automatic set_arvalid(input int m, input logic v);
        if (m == 1) arvalid_m1 = v; else arvalid_m0 = v;
    endtask

    task automatic set_rready(input int m, input logic v);
        if (m == 1) rready_m1 = v; else rready_m0 = v;
    endtask

    task automatic pulse_rst;
        tick;
        rst = 1'b1;
        #1;
        check("pulse_rst/busy", o_busy, 1'b0);
        rst = 1'b0;
    endtask

    // Entered in an IDLE cycle where the winner's request is already driven.
    // Runs one full burst for `win` and returns in the idle gap cycle after
    // the rlast beat.
    task automatic serve(input int win, input int beats, input bit toggle,
                         input bit rereq, input bit late, input string tag);
        int         lose = 1 - win;
        logic [1:0] g    = (win == 1) ? 2'b10 : 2'b01;
        int         n    = 0;
        int         c    = 0;
        logic       rr;
        check({tag, "/idle_grant"},   o_grant, 2'b00);
        check({tag, "/idle_busy"},    o_busy, 1'b0);
        check({tag, "/idle_arvalid"}, o_arvalid1, 1'b0);
        check({tag, "/idle_ar1"},     o_ar1, '0);
        tick;  // ADDR
        check({tag, "/addr_grant"},   o_grant, g);
        check({tag, "/addr_busy"},    o_busy, 1'b1);
        check({tag, "/addr_arvalid"}, o_arvalid1, 1'b1);
        check({tag, "/addr_ar1"},     o_ar1, (win == 1) ? AR1 : AR0);
        // A stray beat during ADDR must not reach the master.
        rvalid1 = 1'b1; r1 = beat(99, 1'b1); set_rready(win, 1'b1);
        #1;
        check({tag, "/addr_stray_rvalid"}, (win == 1) ? o_rvalid_m1 : o_rvalid_m0, 1'b0);
        check({tag, "/addr_rready1"},      o_rready1, 1'b0);
        rvalid1 = 1'b0; r1 = '0; set_rready(win, 1'b0);
        arready1 = 1'b1;
        #1;
        check({tag, "/arready_win"},  (win == 1) ? o_arready_m1 : o_arready_m0, 1'b1);
        check({tag, "/arready_lose"}, (win == 1) ? o_arready_m0 : o_arready_m1, 1'b0);
        tick;  // DATA
        arready1 = 1'b0;
        if (!rereq) set_arvalid(win, 1'b0);
        if (late)   set_arvalid(lose, 1'b1);
        while (n < beats) begin
            rr = toggle ? (c % 2 == 0) : 1'b1;
            rvalid1 = 1'b1;
            r1 = beat(n, n == beats - 1);
            set_rready(win, rr);
            #1;
            check({tag, "/rvalid_win"},   (win == 1) ? o_rvalid_m1 : o_rvalid_m0, 1'b1);
            check({tag, "/r_win"},        (win == 1) ? o_r_m1 : o_r_m0, r1);
            check({tag, "/rready1"},      o_rready1, rr);
            check({tag, "/rvalid_lose"},  (win == 1) ? o_rvalid_m0 : o_rvalid_m1, 1'b0);
            check({tag, "/r_lose"},       (win == 1) ? o_r_m0 : o_r_m1, '0);
            check({tag, "/arready_lose_data"}, (win == 1) ? o_arready_m0 : o_arready_m1, 1'b0);
            check({tag, "/data_grant"},   o_grant, g);
            tick;
            if (rr) n++;
            c++;
        end
        rvalid1 = 1'b0; r1 = '0; set_rready(win, 1'b0);
        #1;
        check({tag, "/gap_busy"},  o_busy, 1'b0);
        check({tag, "/gap_grant"}, o_grant, 2'b00);
    endtask

    initial begin
        // Reset state
        #3;
        check("reset/grant",      o_grant, 2'b00);
        check("reset/busy",       o_busy, 1'b0);
        check("reset/arvalid1",   o_arvalid1, 1'b0);
        check("reset/rready1",    o_rready1, 1'b0);
        check("reset/arready_m0", o_arready_m0, 1'b0);
        check("reset/rvalid_m0",  o_rvalid_m0, 1'b0);
        tick;
        rst = 1'b0;

        // Stray rvalid1 in IDLE with no requests
        rvalid1 = 1'b1; r1 = beat(7, 1'b1); rready_m0 = 1'b1; rready_m1 = 1'b1;
        #1;
        check("stray/rvalid_m0", o_rvalid_m0, 1'b0);
        check("stray/rvalid_m1", o_rvalid_m1, 1'b0);
        check("stray/r_m0",      o_r_m0, '0);
        check("stray/rready1",   o_rready1, 1'b0);
        tick;
        check("stray/busy1",     o_busy, 1'b0);
        check("stray/grant1",    o_grant, 2'b00);
        tick;
        check("stray/busy2",     o_busy, 1'b0);
        check("stray/arvalid1",  o_arvalid1, 1'b0);
        rvalid1 = 1'b0; r1 = '0; rready_m0 = 1'b0; rready_m1 = 1'b0;

        // Single m0 request, 8-beat burst
        tick;
        arvalid_m0 = 1'b1;
        #1;
        serve(0, 8, 1'b0, 1'b0, 1'b0, "single");

        // Round-robin ties: 01,10,01,10
        pulse_rst;
        tick;
        arvalid_m0 = 1'b1; arvalid_m1 = 1'b1;
        #1;
        serve(0, 2, 1'b0, 1'b1, 1'b0, "rr1");
        serve(1, 2, 1'b0, 1'b1, 1'b0, "rr2");
        serve(0, 2, 1'b0, 1'b1, 1'b0, "rr3");
        serve(1, 2, 1'b0, 1'b0, 1'b0, "rr4");
        arvalid_m0 = 1'b0; arvalid_m1 = 1'b0;
        pulse_rst;

        // Fixed priority ties: m0 every time, m1 keeps waiting
        use_fp = 1'b1;
        tick;
        arvalid_m0 = 1'b1; arvalid_m1 = 1'b1;
        #1;
        serve(0, 2, 1'b0, 1'b1, 1'b0, "fp1");
        serve(0, 2, 1'b0, 1'b1, 1'b0, "fp2");
        serve(0, 2, 1'b0, 1'b1, 1'b0, "fp3");
        arvalid_m0 = 1'b0; arvalid_m1 = 1'b0;
        pulse_rst;
        use_fp = 1'b0;

        // m1 requests mid-burst while rready_m0 toggles; served after the gap
        tick;
        arvalid_m0 = 1'b1;
        #1;
        serve(0, 6, 1'b1, 1'b0, 1'b1, "hold");
        serve(1, 2, 1'b0, 1'b0, 1'b0, "pend");

        // Asynchronous reset at beat 3 of 8
        tick;
        arvalid_m0 = 1'b1;
        tick;  // ADDR
        arready1 = 1'b1;
        tick;  // DATA
        arready1 = 1'b0; arvalid_m0 = 1'b0; rready_m0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rvalid1 = 1'b1; r1 = beat(i, 1'b0);
            tick;
        end
        rvalid1 = 1'b1; r1 = beat(3, 1'b0);
        #1;
        check("arst/pre_rvalid_m0", o_rvalid_m0, 1'b1);
        rst = 1'b1;
        #1;
        check("arst/grant",      o_grant, 2'b00);
        check("arst/busy",       o_busy, 1'b0);
        check("arst/rvalid_m0",  o_rvalid_m0, 1'b0);
        check("arst/r_m0",       o_r_m0, '0);
        check("arst/rready1",    o_rready1, 1'b0);
        check("arst/arvalid1",   o_arvalid1, 1'b0);
        check("arst/arready_m0", o_arready_m0, 1'b0);
        tick;
        rst = 1'b0;
        rvalid1 = 1'b0; r1 = '0; rready_m0 = 1'b0;
        arvalid_m1 = 1'b1;
        #1;
        serve(1, 2, 1'b0, 1'b0, 1'b0, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
